// File: rtl/gate_sequencer.sv
// gate_sequencer: applies a stream of two-input gate instructions to a small
// wire register file. An external 16-function gate does the logic; this block
// fetches instructions, selects the operand wires and writes the result back.
// Flow: IDLE (load wires) -> RUN (fetch/execute) -> DONE (present result).

module gate_sequencer #(
  parameter int WIRES = 16,
  parameter int IDXW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  // initial wire vector
  input  logic             load_valid,
  input  logic [WIRES-1:0] load_data,
  output logic             load_ready,
  // gate instruction stream
  input  logic             ins_valid,
  input  logic [16:0]      ins_data,
  output logic             ins_ready,
  // external gate
  output logic [3:0]       gate_choice,
  output logic             gate_a,
  output logic             gate_b,
  input  logic             gate_c,
  // final wire vector
  output logic             res_valid,
  output logic [WIRES-1:0] res_data,
  input  logic             res_ready,
  // status
  output logic             busy,
  output logic [15:0]      gate_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Field layout of ins_data, most significant field first.
  typedef struct packed {
    logic            last;
    logic [3:0]      code;
    logic [IDXW-1:0] src_a;
    logic [IDXW-1:0] src_b;
    logic [IDXW-1:0] dst;
  } ins_t;

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  state_e           state_q,     state_d;
  logic [WIRES-1:0] wires_q,     wires_d;
  ins_t             ex_q,        ex_d;
  logic             ex_valid_q,  ex_valid_d;
  logic             last_seen_q, last_seen_d;
  logic [15:0]      count_q,     count_d;

  ins_t             ins_in;
  logic             ins_accept;

  assign ins_in = ins_t'(ins_data);

  // Next-state logic and all handshake / gate outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d     = state_q;
    wires_d     = wires_q;
    ex_d        = ex_q;
    ex_valid_d  = 1'b0;
    last_seen_d = last_seen_q;
    count_d     = count_q;
    load_ready  = 1'b0;
    ins_ready   = 1'b0;
    ins_accept  = 1'b0;
    res_valid   = 1'b0;
    gate_choice = 4'd0;
    gate_a      = 1'b0;
    gate_b      = 1'b0;

    // Execute stage: operands are read from the current wire values, so an
    // aliased dst is seen with its pre-write value within the same cycle.
    if (ex_valid_q) begin
      gate_choice       = ex_q.code;
      gate_a            = wires_q[ex_q.src_a];
      gate_b            = wires_q[ex_q.src_b];
      wires_d[ex_q.dst] = gate_c;
      if (count_q != COUNT_MAX) begin
        count_d = count_q + 16'd1;
      end
      if (ex_q.last) begin
        state_d = ST_DONE;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          wires_d     = load_data;
          count_d     = 16'd0;
          last_seen_d = 1'b0;
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        // Once the last instruction is taken, the stream is closed for this run.
        ins_ready  = ~last_seen_q;
        ins_accept = ins_valid & ~last_seen_q;
        if (ins_accept) begin
          ex_d       = ins_in;
          ex_valid_d = 1'b1;
          if (ins_in.last) begin
            last_seen_d = 1'b1;
          end
        end
      end

      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; a pending instruction is dropped.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      // NOTE: the wire file is a plain 16-bit register, not a RAM, so it is
      // reset along with the control state; res_data reads zero after reset.
      wires_q     <= '0;
      ex_q        <= '0;
      ex_valid_q  <= 1'b0;
      last_seen_q <= 1'b0;
      count_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      wires_q     <= wires_d;
      ex_q        <= ex_d;
      ex_valid_q  <= ex_valid_d;
      last_seen_q <= last_seen_d;
      count_q     <= count_d;
    end
  end

  assign res_data   = wires_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign gate_count = count_q;

endmodule
